ctrl_pa20: RTL and testbench
============================

# ctrl_pa20

Sequencing controller for the second-order high-pass (20 Hz) filter datapath. On each sample strobe it walks the shared multiply-accumulate unit through the five products of the direct-form-II recursion. It drives the mux bank selects and the register enables for Y(K), F(K), F(K-1) and F(K-2), then shifts the history and signals completion. It sits between the sample-rate timer/ADC interface and the filter datapath, one instance per filter.

## Interface
- `MUL_LAT`, default 0: extra wait cycles per MAC step for a multi-cycle arithmetic path (0–7).
- `clk`, input, 1: system clock; all state changes on rising edge.
- `reset`, input, 1: synchronous, active-high; shared with the datapath registers.
- `start`, input, 1: one-cycle sample strobe; new `UK` is stable from this cycle until `done`.
- `clr_ovr`, input, 1: clears `overrun`.
- `muxS`, output, 3: signal select. 000 UK, 001 F(K), 010 F(K-1), 011 F(K-2), 100 Y(K).
- `muxC`, output, 2: coefficient select. 00 b0, 01 b1, 10 −a1, 11 −a2.
- `muxZ`, output, 2: addend select. 00 zero, 01 UK, 10 F(K), 11 Y(K).
- `en1`, output, 1: load Y(K) from the arithmetic result.
- `en2`, output, 1: load F(K) from the arithmetic result.
- `en3`, output, 1: load F(K-1) from F(K).
- `en4`, output, 1: load F(K-2) from F(K-1).
- `busy`, output, 1: high from the first compute state through DONE.
- `done`, output, 1: one-cycle pulse; `YK` is valid for the new sample.
- `overrun`, output, 1: sticky; a `start` arrived while a sample was in progress.

## Operation
- Arithmetic: result = dato1·dato2 + dato3.
- Moore FSM: IDLE → F1 → F2 → Y0 → Y1 → Y2 → SHIFT → DONE → IDLE.
- F1: S=010, C=10, Z=01, en2. F(K) ← −a1·F(K-1) + UK.
- F2: S=011, C=11, Z=10, en2. F(K) ← −a2·F(K-2) + F(K).
- Y0: S=001, C=00, Z=00, en1. Y ← b0·F(K).
- Y1: S=010, C=01, Z=11, en1. Y ← b1·F(K-1) + Y.
- Y2: S=011, C=00, Z=11, en1. Y ← b0·F(K-2) + Y. b2 = b0 for the high-pass, so C=00 is reused.
- SHIFT: en3 and en4 both high in the same cycle. Both registers capture pre-edge values, so the history shifts correctly.
- DONE: `done`=1, all enables 0.
- IDLE, SHIFT, DONE: mux outputs 000/00/00.
- Reset values: state IDLE; all outputs 0, including `overrun`.
- `start` in IDLE or DONE: accepted; next state is F1. Back-to-back samples are allowed from DONE.
- `start` in F1..SHIFT: ignored and sets `overrun`. The current sample completes normally.
- `clr_ovr` and an overrun event in the same cycle: set wins.
- `reset` mid-sequence: IDLE on the next edge with no enable asserted. The datapath is cleared by the same reset.
- Each enable is high for exactly one cycle per state.

## Timing
- `start` sampled high at edge t0 ⇒ F1 occupies the cycle after t0.
- Each compute state (F1..Y2) lasts MUL_LAT+1 cycles. Selects are held for the whole state; the enable is asserted only in its final cycle.
- SHIFT and DONE last 1 cycle each.
- `done` is high 5·(MUL_LAT+1)+2 cycles after the start edge, i.e. 7 cycles for MUL_LAT=0.
- Y(K) is updated at the end of Y2 and is stable while `done`=1 and until the next Y0.
- `busy` falls the cycle after DONE unless a new `start` was accepted in DONE.

## Structure
- Add to constantes.h: state codes and the muxS/muxC/muxZ select codes above.
- One sub-module: `cont_lat`, a 3-bit down-counter loaded with MUL_LAT on state entry, flagging the last cycle of the step.
- The FSM stays in `ctrl_pa20`.

## Test plan
- **Basic sequence:** MUL_LAT=0, `start` at cycle 10 → en2 high at 11,12; en1 at 13,14,15; en3=en4=1 at 16; `done` at 17. Mux codes match the table each cycle; `busy` high 11–17.
- **Overrun:** `start` at 10 and 13 → second start ignored; `overrun`=1 from 14; `done` still at 17 only. `clr_ovr` at 20 → `overrun`=0 at 21.
- **Back-to-back:** `start` during the DONE cycle (17) → F1 at 18; `done` again at 24; `overrun` stays 0.
- **Reset mid-sequence:** `reset` high in Y0 (cycle 13) → cycle 14 all outputs 0, state IDLE, no en1 pulse.
- **Latency parameter:** MUL_LAT=2, `start` at 10 → en2 high only at 13 and 16; selects constant over each 3-cycle state; `done` at 27.
- **Closed loop with datapath:** unit impulse on UK (b0=1.0, b1=−2.0, a1=a2=0) → Y = 1.0, −2.0, 1.0, 0 for four consecutive samples.

Source files
------------

// File: rtl/ctrl_pa20_pkg.sv
// Shared constants, state codes and the control-word payload for the
// second-order high-pass filter sequencer.
package ctrl_pa20_pkg;

  localparam int unsigned LAT_W   = 3;
  localparam int unsigned SEL_S_W = 3;
  localparam int unsigned SEL_C_W = 2;
  localparam int unsigned SEL_Z_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_F1    = 3'd1,
    ST_F2    = 3'd2,
    ST_Y0    = 3'd3,
    ST_Y1    = 3'd4,
    ST_Y2    = 3'd5,
    ST_SHIFT = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [SEL_S_W-1:0] S_UK  = 3'b000;
  localparam logic [SEL_S_W-1:0] S_FK  = 3'b001;
  localparam logic [SEL_S_W-1:0] S_FK1 = 3'b010;
  localparam logic [SEL_S_W-1:0] S_FK2 = 3'b011;

  localparam logic [SEL_C_W-1:0] C_B0  = 2'b00;
  localparam logic [SEL_C_W-1:0] C_B1  = 2'b01;
  localparam logic [SEL_C_W-1:0] C_NA1 = 2'b10;
  localparam logic [SEL_C_W-1:0] C_NA2 = 2'b11;

  localparam logic [SEL_Z_W-1:0] Z_ZERO = 2'b00;
  localparam logic [SEL_Z_W-1:0] Z_UK   = 2'b01;
  localparam logic [SEL_Z_W-1:0] Z_FK   = 2'b10;
  localparam logic [SEL_Z_W-1:0] Z_YK   = 2'b11;

  typedef struct packed {
    logic [SEL_S_W-1:0] mux_s;
    logic [SEL_C_W-1:0] mux_c;
    logic [SEL_Z_W-1:0] mux_z;
    logic               en1;
    logic               en2;
    logic               en3;
    logic               en4;
    logic               busy;
    logic               done;
  } ctrl_out_t;

  // Control word for a state; 'last' marks the final cycle of a MAC step.
  function automatic ctrl_out_t decode(input state_e st, input logic last);
    ctrl_out_t o;
    o       = '0;
    o.mux_s = S_UK;
    o.mux_c = C_B0;
    o.mux_z = Z_ZERO;
    o.busy  = (st != ST_IDLE);
    unique case (st)
      ST_F1:    begin o.mux_s = S_FK1; o.mux_c = C_NA1; o.mux_z = Z_UK;   o.en2 = last; end
      ST_F2:    begin o.mux_s = S_FK2; o.mux_c = C_NA2; o.mux_z = Z_FK;   o.en2 = last; end
      ST_Y0:    begin o.mux_s = S_FK;  o.mux_c = C_B0;  o.mux_z = Z_ZERO; o.en1 = last; end
      ST_Y1:    begin o.mux_s = S_FK1; o.mux_c = C_B1;  o.mux_z = Z_YK;   o.en1 = last; end
      // b2 equals b0 for this high-pass, so the b0 coefficient is reused
      ST_Y2:    begin o.mux_s = S_FK2; o.mux_c = C_B0;  o.mux_z = Z_YK;   o.en1 = last; end
      ST_SHIFT: begin o.en3 = 1'b1; o.en4 = 1'b1; end
      ST_DONE:  o.done = 1'b1;
      ST_IDLE:  o.busy = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_pa20_cont_lat.sv
// Per-step latency counter: reloads with MUL_LAT on each state entry and
// flags the final cycle of the step (current and next-cycle views).
module cont_lat
  import ctrl_pa20_pkg::*;
#(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic last_c,
  output logic last_nxt_c
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c     = (cnt_q == '0);
  assign last_nxt_c = (cnt_d == '0);

endmodule

// File: rtl/ctrl_pa20.sv
// Sequencer for the DF-II high-pass datapath: five MAC steps, history shift,
// done pulse, with sticky overrun detection for early sample strobes.
module ctrl_pa20
  import ctrl_pa20_pkg::*;
#(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clr_ovr,
  output logic [SEL_S_W-1:0] muxS,
  output logic [SEL_C_W-1:0] muxC,
  output logic [SEL_Z_W-1:0] muxZ,
  output logic               en1,
  output logic               en2,
  output logic               en3,
  output logic               en4,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  state_e    state_q, state_d;
  ctrl_out_t out_q, out_d;
  logic      overrun_q, overrun_d;
  logic      load_c, last_c, last_nxt_c, ovr_set_c;

  cont_lat #(.MUL_LAT(MUL_LAT)) u_cont_lat (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .last_c     (last_c),
    .last_nxt_c (last_nxt_c)
  );

  // Next state; compute states advance only on their last latency cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)  state_d = ST_F1;
      ST_F1:    if (last_c) state_d = ST_F2;
      ST_F2:    if (last_c) state_d = ST_Y0;
      ST_Y0:    if (last_c) state_d = ST_Y1;
      ST_Y1:    if (last_c) state_d = ST_Y2;
      ST_Y2:    if (last_c) state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_F1 : ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered word lines up with state_q.
  always_comb begin
    load_c    = (state_d != state_q);
    out_d     = decode(state_d, last_nxt_c);
    ovr_set_c = start && (state_q != ST_IDLE) && (state_q != ST_DONE);
    overrun_d = overrun_q;
    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
    end
  end

  assign muxS    = out_q.mux_s;
  assign muxC    = out_q.mux_c;
  assign muxZ    = out_q.mux_z;
  assign en1     = out_q.en1;
  assign en2     = out_q.en2;
  assign en3     = out_q.en3;
  assign en4     = out_q.en4;
  assign busy    = out_q.busy;
  assign done    = out_q.done;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ctrl_pa20.sv
// Bench for ctrl_pa20: two instances (MUL_LAT 0 and 2) against a schedule
// model, plus a closed-loop impulse through a small integer datapath.
module tb_ctrl_pa20;

  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic clr_ovr = 1'b0;

  logic [2:0] s0, s1;
  logic [1:0] c0, c1, z0, z1;
  logic e10, e20, e30, e40, b0o, d0, o0;
  logic e11, e21, e31, e41, b1o, d1, o1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pa20 #(.MUL_LAT(LAT0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .clr_ovr(clr_ovr),
    .muxS(s0), .muxC(c0), .muxZ(z0), .en1(e10), .en2(e20), .en3(e30), .en4(e40),
    .busy(b0o), .done(d0), .overrun(o0)
  );

  ctrl_pa20 #(.MUL_LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .clr_ovr(clr_ovr),
    .muxS(s1), .muxC(c1), .muxZ(z1), .en1(e11), .en2(e21), .en3(e31), .en4(e41),
    .busy(b1o), .done(d1), .overrun(o1)
  );

  // Reference model: cycles elapsed since the accepted start (0 = idle).
  int   off [2] = '{0, 0};
  logic ovr [2] = '{1'b0, 1'b0};

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // Expected {muxS, muxC, muxZ, en1, en2, en3, en4, busy, done}.
  function automatic logic [12:0] exp_out(input int o, input int lat);
    int sl, comp, k, st;
    logic [2:0] s;
    logic [1:0] c, z;
    logic fire;
    sl   = lat + 1;
    comp = 5 * sl;
    if (o == 0) return 13'd0;
    if (o <= comp) begin
      k    = o - 1;
      st   = k / sl;
      fire = ((k % sl) == lat);
      case (st)
        0:       begin s = 3'b010; c = 2'b10; z = 2'b01; end
        1:       begin s = 3'b011; c = 2'b11; z = 2'b10; end
        2:       begin s = 3'b001; c = 2'b00; z = 2'b00; end
        3:       begin s = 3'b010; c = 2'b01; z = 2'b11; end
        default: begin s = 3'b011; c = 2'b00; z = 2'b11; end
      endcase
      return {s, c, z, fire && (st >= 2), fire && (st < 2), 1'b0, 1'b0, 1'b1, 1'b0};
    end
    if (o == comp + 1) return {7'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    return {7'd0, 4'b0000, 1'b1, 1'b1};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int dn;
      dn = 5 * (lat_of(i) + 1) + 2;
      if (reset) begin
        off[i] <= 0;
        ovr[i] <= 1'b0;
      end else begin
        if (start && off[i] != 0 && off[i] != dn) ovr[i] <= 1'b1;
        else if (clr_ovr) ovr[i] <= 1'b0;
        if (start && (off[i] == 0 || off[i] == dn)) off[i] <= 1;
        else if (off[i] == dn) off[i] <= 0;
        else if (off[i] != 0) off[i] <= off[i] + 1;
      end
    end
  end

  // Integer datapath closed around dut0: b0=1, b1=-2, -a1=-a2=0.
  int uk = 0, fk = 0, fk1 = 0, fk2 = 0, yk = 0;

  function automatic int mac(input logic [2:0] s, input logic [1:0] c, input logic [1:0] z,
                             input int u, input int f, input int f1, input int f2, input int y);
    int sig, coef, add;
    case (s)
      3'b000: sig = u;
      3'b001: sig = f;
      3'b010: sig = f1;
      3'b011: sig = f2;
      default: sig = y;
    endcase
    case (c)
      2'b00: coef = 1;
      2'b01: coef = -2;
      default: coef = 0;
    endcase
    case (z)
      2'b00: add = 0;
      2'b01: add = u;
      2'b10: add = f;
      default: add = y;
    endcase
    return sig * coef + add;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0;
    end else begin
      if (e10) yk  <= mac(s0, c0, z0, uk, fk, fk1, fk2, yk);
      if (e20) fk  <= mac(s0, c0, z0, uk, fk, fk1, fk2, yk);
      if (e30) fk1 <= fk;
      if (e40) fk2 <= fk1;
    end
  end

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare both DUTs at the falling edge, then drive this cycle's inputs.
  task automatic step(input logic s, input logic c, input logic r);
    @(negedge clk);
    chk("ctrl_lat0", {s0, c0, z0, e10, e20, e30, e40, b0o, d0}, exp_out(off[0], LAT0));
    chk("ovr_lat0", {12'd0, o0}, {12'd0, ovr[0]});
    chk("ctrl_lat2", {s1, c1, z1, e11, e21, e31, e41, b1o, d1}, exp_out(off[1], LAT1));
    chk("ovr_lat2", {12'd0, o1}, {12'd0, ovr[1]});
    start   = s;
    clr_ovr = c;
    reset   = r;
  endtask

  initial begin
    int exp_y [4] = '{1, -2, 1, 0};
    logic got;

    repeat (2) @(posedge clk);
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (3) step(0, 0, 0);

    // Basic sequence, then a second strobe mid-sequence (overrun)
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    repeat (30) step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // Back-to-back: strobe exactly in the lat-0 DONE cycle
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    step(1, 0, 0);
    repeat (30) step(0, 0, 0);

    // Reset during Y0, and clr/set collision
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (30) step(0, 0, 0);

    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
    end

    // Closed-loop unit impulse through the datapath
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      uk = (i == 0) ? 1 : 0;
      step(1, 0, 0);
      got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
        step(0, 0, 0);
        if (d0 === 1'b1) got = 1'b1;
      end
      chk("done_seen", {12'd0, got}, 13'd1);
      chk("yk", 13'(yk), 13'(exp_y[i]));
    end
    repeat (20) step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
